neuron_mac_seq: RTL and testbench



---
 rtl/neuron_mac_seq.sv | 75 +++++++
 tb/tb_neuron_mac_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequencer and accumulator register around an external multiply-add stage for one neuron dot product
module neuron_mac_seq #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_ACC = 32,
  parameter int CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  input  logic [WIDTH_ACC-1:0] bias_in,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  x_in,
  input  logic [WIDTH_IN-1:0]  w_in,
  output logic [WIDTH_IN-1:0]  mac_a,
  output logic [WIDTH_IN-1:0]  mac_b,
  output logic [WIDTH_ACC-1:0] mac_c,
  input  logic [WIDTH_ACC-1:0] mac_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_ACC-1:0] acc_out,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH_ACC-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  assign mac_a     = x_in;
  assign mac_b     = w_in;
  assign mac_c     = acc;
  assign acc_out   = acc;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  // state, accumulator and remaining-term count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
    end
  end
  // next state: abort overrides everything; the final accepted pair closes the loop into DONE
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    if (abort) begin
      state_nx = IDLE;
      acc_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc_nx   = bias_in;
          cnt_nx   = len;
          state_nx = (len == '0) ? DONE : ACCUM;
        end
        ACCUM: if (in_valid) begin
          acc_nx   = mac_y;
          cnt_nx   = cnt - 1'b1;
          state_nx = (cnt == CNT_W'(1)) ? DONE : ACCUM;
        end
        DONE: state_nx = out_ready ? IDLE : DONE;
        default: state_nx = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: scoreboard bench with a signed multiply-add stage model closing the loop
module tb_neuron_mac_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [9:0] len = '0;
  logic [31:0] bias_in = '0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] x_in = '0;
  logic [15:0] w_in = '0;
  logic [15:0] mac_a, mac_b;
  logic [31:0] mac_c, mac_y;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] acc_out;
  logic busy;
  logic signed [31:0] prod;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int checks = 0;
  int errors = 0;
  int acc_n = 0;
  int rdy_n = 0;

  neuron_mac_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias_in(bias_in),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_y(mac_y),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .busy(busy)
  );

  assign prod  = $signed(mac_a) * $signed(mac_b);
  assign mac_y = prod + mac_c;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (in_valid && in_ready) acc_n <= acc_n + 1;
    if (in_ready) rdy_n <= rdy_n + 1;
  end

  function automatic logic [31:0] mul(input logic [15:0] x, input logic [15:0] w);
    logic signed [31:0] p;
    p = $signed(x) * $signed(w);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [9:0] l, input logic [31:0] b);
    start = 1'b1;
    len = l;
    bias_in = b;
    tick();
    start = 1'b0;
    len = $urandom;
    bias_in = $urandom;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({in_ready, out_valid, busy, acc_out, mac_c} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b ov=%b busy=%b acc=%h macc=%h want all 0", in_ready, out_valid, busy, acc_out, mac_c);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_q.push_back(32'h10 + mul(16'd2, 16'd3) + mul(16'd4, 16'd5) + mul(16'hFFFF, 16'd6));
    start_run(10'd3, 32'h0000_0010);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready got rdy=%b busy=%b want 1 1", in_ready, busy);
    end
    in_valid = 1'b1;
    x_in = 16'd2; w_in = 16'd3; tick();
    x_in = 16'd4; w_in = 16'd5; tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid got %b want 0", out_valid);
    end
    x_in = 16'hFFFF; w_in = 16'd6; tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 32'h0000_0024) begin
      errors++;
      $display("FAIL basic_result got ov=%b acc=%h want 1 00000024", out_valid, acc_out);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (acc_out !== exp_v) begin
      errors++;
      $display("FAIL basic_sb got %h want %h", acc_out, exp_v);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got busy=%b ov=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_empty();
    int r0;
    r0 = rdy_n;
    exp_q.push_back(32'h1234_5678);
    start_run(10'd0, 32'h1234_5678);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL empty_valid got ov=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (acc_out !== exp_v) begin
      errors++;
      $display("FAIL empty_sb got %h want %h", acc_out, exp_v);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (rdy_n != r0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_no_ready got ready_cycles=%0d busy=%b want 0 0", rdy_n - r0, busy);
    end
  endtask

  task automatic test_back_pressure();
    logic [6:0] pat;
    logic [31:0] e;
    int a0;
    pat = 7'b1011001;
    e = 32'hFFFF_FF00;
    a0 = acc_n;
    start_run(10'd4, e);
    for (int i = 0; i < 7; i++) begin
      x_in = $urandom;
      w_in = $urandom;
      in_valid = pat[i];
      start = (i == 2);
      if (pat[i]) e = e + mul(x_in, w_in);
      tick();
    end
    in_valid = 1'b0;
    start = 1'b0;
    exp_q.push_back(e);
    checks++;
    if (out_valid !== 1'b1 || acc_n - a0 != 4) begin
      errors++;
      $display("FAIL bp_accept got ov=%b pairs=%0d want 1 4", out_valid, acc_n - a0);
    end
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      checks++;
      if (out_valid !== 1'b1 || acc_out !== e) begin
        errors++;
        $display("FAIL bp_hold%0d got ov=%b acc=%h want 1 %h", i, out_valid, acc_out, e);
      end
      tick();
    end
    start = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (acc_out !== exp_v || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_sb got acc=%h rdy=%b want %h 0", acc_out, in_ready, exp_v);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || acc_n - a0 != 4) begin
      errors++;
      $display("FAIL bp_idle got busy=%b pairs=%0d want 0 4", busy, acc_n - a0);
    end
  endtask

  task automatic test_wrap();
    exp_q.push_back(32'h8000_0000);
    start_run(10'd1, 32'h7FFF_FFFF);
    in_valid = 1'b1; x_in = 16'd1; w_in = 16'd1;
    tick();
    in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || acc_out !== exp_v) begin
      errors++;
      $display("FAIL wrap got ov=%b acc=%h want 1 %h", out_valid, acc_out, exp_v);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    start_run(10'd5, 32'h0000_0100);
    in_valid = 1'b1; x_in = 16'd7; w_in = 16'd9;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mac_c !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b rdy=%b acc=%h ov=%b want 0 0 0 0", busy, in_ready, mac_c, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_out got %b want 0", out_valid);
    end
    start = 1'b1; abort = 1'b1; len = 10'd2; bias_in = 32'h55;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || acc_out !== 32'h0) begin
      errors++;
      $display("FAIL abort_start_same got busy=%b acc=%h want 0 0", busy, acc_out);
    end
    exp_q.push_back(32'h0000_0009);
    start_run(10'd1, 32'h0);
    in_valid = 1'b1; x_in = 16'd3; w_in = 16'd3;
    tick();
    in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || acc_out !== exp_v) begin
      errors++;
      $display("FAIL abort_rerun got ov=%b acc=%h want 1 %h", out_valid, acc_out, exp_v);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_run(10'd3, 32'h0000_0040);
    in_valid = 1'b1; x_in = 16'd5; w_in = 16'd5;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, acc_out, mac_c} !== '0) begin
      errors++;
      $display("FAIL reset_accum got rdy=%b ov=%b busy=%b acc=%h want all 0", in_ready, out_valid, busy, acc_out);
    end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    start_run(10'd0, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_done got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, acc_out, mac_c} !== '0) begin
      errors++;
      $display("FAIL reset_done got rdy=%b ov=%b busy=%b acc=%h want all 0", in_ready, out_valid, busy, acc_out);
    end
    tick();
    rst_n = 1'b1;
    exp_q.push_back(32'h0000_0003 + mul(16'hFFFE, 16'd7) + mul(16'd100, 16'hFF00));
    start_run(10'd2, 32'h0000_0003);
    in_valid = 1'b1; x_in = 16'hFFFE; w_in = 16'd7;
    tick();
    x_in = 16'd100; w_in = 16'hFF00;
    tick();
    in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || acc_out !== exp_v) begin
      errors++;
      $display("FAIL reset_rerun got ov=%b acc=%h want 1 %h", out_valid, acc_out, exp_v);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_back_pressure();
    test_wrap();
    test_abort();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL final got pending=%0d busy=%b want 0 0", exp_q.size(), busy);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
